eth_decap: RTL and testbench
============================

ETH_DECAP -- requirements
Module: eth_decap

Interface
REQ-001 SHALL have parameter LOCAL_MAC, default 48'h00_11_22_33_44_55, meaning the unicast destination MAC the block accepts, byte 0 in [47:40].
REQ-002 SHALL have parameter ETHERTYPE, default 16'h88B5, meaning the tunnel EtherType, first wire byte in [15:8].
REQ-003 SHALL have one clock, clk156 (input, 1), for all logic, with rising-edge sampling.
REQ-004 SHALL have reset sys_rst (input, 1); it is asynchronous and active-high.
REQ-005 SHALL have MAC RX stream inputs: s_axis_tvalid 1, s_axis_tdata 64 (wire byte n in [8n+7:8n]), s_axis_tkeep 8, s_axis_tlast 1, s_axis_tuser 1 (1 = good frame, valid on tlast); there is no tready.
REQ-006 SHALL have FIFO write outputs: wr_en 1 and din 74 = {err, last, keep[7:0], data[63:0]}, plus input full 1.
REQ-007 SHALL have counter outputs, each 32 bits: frames_ok, frames_drop and overflow_cnt.

Function
REQ-008 Frame format: word0 = dst MAC bytes 0-5 plus src MAC bytes 0-1; word1 = src bytes 2-5, EtherType in bytes 4-5, sequence in bytes 6-7; word2 onward is the payload (TLP stream).
REQ-009 FSM states: HDR0, HDR1, PAYLOAD, DROP. Reset state is HDR0. The FSM advances only on beats with s_axis_tvalid=1.
REQ-010 HDR0: latch the dst MAC match, where dst equals LOCAL_MAC or FF:FF:FF:FF:FF:FF. Go to HDR1. If tlast: runt frame, frames_drop+1, stay in HDR0.
REQ-011 HDR1: go to PAYLOAD if dst matched and EtherType equals ETHERTYPE and term_pend=0. Otherwise go to DROP, or to HDR0 if tlast.
REQ-012 HDR1 with tlast: runt frame, frames_drop+1, go to HDR0, write nothing.
REQ-013 PAYLOAD beat with full=0: write the beat. wr_en=1 and din={~tuser&tlast, tlast, tkeep, tdata}.
REQ-014 PAYLOAD timing: the write is registered, so wr_en/din appear exactly 1 cycle after the input beat.
REQ-015 PAYLOAD tlast: go to HDR0. If tuser=1, frames_ok+1; else frames_drop+1, and the FIFO word carries err=1.
REQ-016 PAYLOAD beat with full=1: discard the beat, set term_pend, overflow_cnt+1 and frames_drop+1 (once per frame). Go to DROP, or to HDR0 if tlast.
REQ-017 DROP: discard beats until tlast, then go to HDR0. frames_drop increments once per frame, counted at the HDR1 decision or at the overflow.
REQ-018 term_pend: on the first cycle with full=0 and no payload write scheduled, write one terminator word {err=1, last=1, keep=8'h00, data=0}, then clear term_pend.
REQ-019 A frame whose HDR1 is seen while term_pend=1 SHALL be dropped entirely and counted in frames_drop.
REQ-020 wr_en SHALL never assert in a cycle where full was 1 at the time of the write decision, and SHALL be at most 1 word per cycle.
REQ-021 Non-last payload beats SHALL carry tkeep as received; no byte realignment is performed.
REQ-022 Counters SHALL wrap modulo 2^32.
REQ-023 s_axis_tvalid=0 gaps inside a frame SHALL hold state without side effects.

Reset
REQ-024 While sys_rst=1: state=HDR0, term_pend=0, wr_en=0, din=0 and all counters=0, applied asynchronously.
REQ-025 Deassertion SHALL be synchronised to clk156 internally. The first beat accepted after reset is treated as HDR0.
REQ-026 Reset mid-frame SHALL abandon the frame without writing a terminator. Downstream is reset by the same sys_rst.

Verification
REQ-027 Good frame: 2 header words (dst=LOCAL_MAC, type 88B5) + 3 payload words, last tkeep=8'h0F, tuser=1 -> 3 writes 1 cycle delayed, the last being {0,1,0F,data}, and frames_ok=1.
REQ-028 Wrong EtherType 0800, 6 words -> no writes, frames_drop=1, and the next good frame is accepted normally.
REQ-029 Bad CRC: good header + 2 payload words, tuser=0 on tlast -> 2 writes, the final word err=1 last=1, and frames_drop=1.
REQ-030 Overflow: full=1 asserted on 2nd of 4 payload words, released 3 cycles after tlast -> 1 payload write, then exactly one terminator {1,1,00,0}; overflow_cnt=1 and frames_drop=1.
REQ-031 Runt: single-beat frame (tlast in HDR0) and a two-beat frame -> no writes and frames_drop=2.
REQ-032 Async reset asserted mid-PAYLOAD without clock edge -> wr_en=0 and counters=0 immediately; the next frame decodes from HDR0.

Source files
------------

// File: rtl/eth_decap_if.sv
// ---------------------------------------------------------------------------
// eth_decap_if
// Bundles the MAC RX stream (no back-pressure) and the FIFO write port seen by
// the Ethernet tunnel decapsulator.
//   s_axis_tvalid/tdata/tkeep/tlast/tuser : RX beat, wire byte n in [8n+7:8n],
//                                           tuser = good frame, valid on tlast
//   wr_en / din[73:0]                     : FIFO write, din = {err,last,keep,data}
//   full                                  : FIFO cannot take a word this cycle
// master = environment (MAC + FIFO), slave = eth_decap.
// ---------------------------------------------------------------------------
interface eth_decap_if;
    logic        s_axis_tvalid;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        wr_en;
    logic [73:0] din;
    logic        full;

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser,
        output full,
        input  wr_en, din
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser,
        input  full,
        output wr_en, din
    );
endinterface

// File: rtl/eth_decap.sv
// ---------------------------------------------------------------------------
// eth_decap
// Strips the two-word Ethernet tunnel header (dst/src MAC, EtherType,
// sequence) from frames addressed to LOCAL_MAC or broadcast with the tunnel
// EtherType, and forwards the payload words into a FIFO one cycle later.
// Frames that cannot complete because the FIFO filled are closed downstream
// with a single terminator word {err=1,last=1,keep=0,data=0}.
// Ports:
//   clk156        : single clock, rising edge
//   sys_rst       : asynchronous active-high reset, release synchronised here
//   bus           : eth_decap_if.slave (RX stream in, FIFO write out)
//   frames_ok     : frames fully delivered with good status
//   frames_drop   : frames dropped (runt, filtered, overflowed, bad CRC)
//   overflow_cnt  : frames truncated because the FIFO was full
// ---------------------------------------------------------------------------
module eth_decap #(
    parameter logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic        clk156,
    input  logic        sys_rst,
    eth_decap_if.slave  bus,
    output logic [31:0] frames_ok,
    output logic [31:0] frames_drop,
    output logic [31:0] overflow_cnt
);

    typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD, DROP} state_t;

    localparam logic [73:0] TERM_WORD = {1'b1, 1'b1, 8'h00, 64'h0};

    // Reset: asserts immediately, releases two clk156 edges after sys_rst falls.
    logic [1:0] rst_sync_q;
    logic       rst;

    always_ff @(posedge clk156 or posedge sys_rst) begin
        if (sys_rst) rst_sync_q <= 2'b11;
        else         rst_sync_q <= {rst_sync_q[0], 1'b0};
    end

    assign rst = rst_sync_q[1];

    state_t      state_q, state_d;
    logic        dst_match_q, dst_match_d;
    logic        term_pend_q, term_pend_d;
    logic        wr_en_q, wr_en_d;
    logic [73:0] din_q, din_d;
    logic [31:0] frames_ok_q, frames_ok_d;
    logic [31:0] frames_drop_q, frames_drop_d;
    logic [31:0] overflow_cnt_q, overflow_cnt_d;

    logic beat, tlast, tuser, full;
    assign beat  = bus.s_axis_tvalid;
    assign tlast = bus.s_axis_tlast;
    assign tuser = bus.s_axis_tuser;
    assign full  = bus.full;

    // Destination MAC compare, byte by byte: wire byte n holds MAC byte n,
    // and MAC byte 0 sits in the top octet of LOCAL_MAC.
    logic [5:0] uc_byte_hit;
    logic [5:0] bc_byte_hit;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_dst_byte
            assign uc_byte_hit[gi] = (bus.s_axis_tdata[8*gi +: 8] == LOCAL_MAC[47-8*gi -: 8]);
            assign bc_byte_hit[gi] = &bus.s_axis_tdata[8*gi +: 8];
        end
    endgenerate

    logic dst_hit, type_hit, hdr_accept;
    assign dst_hit    = (&uc_byte_hit) | (&bc_byte_hit);
    // EtherType occupies wire bytes 4 (high octet) and 5 (low octet) of word1.
    assign type_hit   = (bus.s_axis_tdata[39:32] == ETHERTYPE[15:8]) &&
                        (bus.s_axis_tdata[47:40] == ETHERTYPE[7:0]);
    // A pending terminator must go out before any new payload can start.
    assign hdr_accept = dst_match_q && type_hit && !term_pend_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk156 or posedge rst) begin
        if (rst) begin
            state_q        <= HDR0;
            dst_match_q    <= 1'b0;
            term_pend_q    <= 1'b0;
            wr_en_q        <= 1'b0;
            din_q          <= '0;
            frames_ok_q    <= '0;
            frames_drop_q  <= '0;
            overflow_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            dst_match_q    <= dst_match_d;
            term_pend_q    <= term_pend_d;
            wr_en_q        <= wr_en_d;
            din_q          <= din_d;
            frames_ok_q    <= frames_ok_d;
            frames_drop_q  <= frames_drop_d;
            overflow_cnt_q <= overflow_cnt_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (beat) begin
            case (state_q)
                HDR0:    state_d = tlast ? HDR0 : HDR1;
                HDR1: begin
                    if (tlast)           state_d = HDR0;
                    else if (hdr_accept) state_d = PAYLOAD;
                    else                 state_d = DROP;
                end
                PAYLOAD: begin
                    if (tlast)     state_d = HDR0;
                    else if (full) state_d = DROP;
                    else           state_d = PAYLOAD;
                end
                DROP:    state_d = tlast ? HDR0 : DROP;
                default: state_d = HDR0;
            endcase
        end
    end

    // ---------------- output / datapath logic ----------------
    logic pay_wr, term_wr, ovf_hit, drop_hit, ok_hit;

    always_comb begin
        pay_wr   = (state_q == PAYLOAD) && beat && !full;
        // Terminator only uses a slot the payload path leaves free.
        term_wr  = term_pend_q && !full && !pay_wr;
        ovf_hit  = (state_q == PAYLOAD) && beat && full;
        ok_hit   = pay_wr && tlast && tuser;
        // Each dropped frame is counted at exactly one decision point.
        drop_hit = ((state_q == HDR0) && beat && tlast) ||
                   ((state_q == HDR1) && beat && (tlast || !hdr_accept)) ||
                   ovf_hit ||
                   (pay_wr && tlast && !tuser);

        wr_en_d = pay_wr || term_wr;
        din_d   = din_q;
        if (pay_wr)
            din_d = {~tuser & tlast, tlast, bus.s_axis_tkeep, bus.s_axis_tdata};
        else if (term_wr)
            din_d = TERM_WORD;

        term_pend_d = term_pend_q;
        if (ovf_hit)      term_pend_d = 1'b1;
        else if (term_wr) term_pend_d = 1'b0;

        dst_match_d = dst_match_q;
        if ((state_q == HDR0) && beat) dst_match_d = dst_hit;

        frames_ok_d    = frames_ok_q    + {31'd0, ok_hit};
        frames_drop_d  = frames_drop_q  + {31'd0, drop_hit};
        overflow_cnt_d = overflow_cnt_q + {31'd0, ovf_hit};
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.din      = din_q;
    assign frames_ok    = frames_ok_q;
    assign frames_drop  = frames_drop_q;
    assign overflow_cnt = overflow_cnt_q;

endmodule

// File: tb/tb_eth_decap.sv
// ---------------------------------------------------------------------------
// tb_eth_decap
// Directed scenarios plus randomized frames. A frame-level reference model
// predicts every FIFO word (with the cycle it must appear) and the counters;
// a monitor pops predictions whenever wr_en is seen.
// ---------------------------------------------------------------------------
module tb_eth_decap;
    localparam logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55;
    localparam logic [15:0] ETHERTYPE = 16'h88B5;
    localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;

    logic        clk156 = 1'b0;
    logic        sys_rst;
    logic [31:0] frames_ok, frames_drop, overflow_cnt;

    always #5 clk156 = ~clk156;

    eth_decap_if bus_if();

    eth_decap #(.LOCAL_MAC(LOCAL_MAC), .ETHERTYPE(ETHERTYPE)) dut (
        .clk156       (clk156),
        .sys_rst      (sys_rst),
        .bus          (bus_if),
        .frames_ok    (frames_ok),
        .frames_drop  (frames_drop),
        .overflow_cnt (overflow_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk156) cyc <= cyc + 1;

    typedef struct {
        logic [73:0] din;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: position inside the current frame and its verdict.
    int          m_idx;
    logic        m_dst_ok, m_accept, m_term;
    logic [31:0] m_ok, m_drop, m_ovf;

    function automatic logic [47:0] wire_dst(input logic [63:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40]};
    endfunction

    function automatic logic [15:0] wire_type(input logic [63:0] d);
        return {d[39:32], d[47:40]};
    endfunction

    function automatic logic [63:0] mk_w0(input logic [47:0] dst, input logic [47:0] src);
        return {src[39:32], src[47:40], dst[7:0], dst[15:8], dst[23:16], dst[31:24], dst[39:32], dst[47:40]};
    endfunction

    function automatic logic [63:0] mk_w1(input logic [47:0] src, input logic [15:0] et, input logic [15:0] seq);
        return {seq[7:0], seq[15:8], et[7:0], et[15:8], src[7:0], src[15:8], src[23:16], src[31:24]};
    endfunction

    task automatic push_exp(input logic [73:0] w);
        exp_t e;
        e.din = w;
        e.at  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_idx = 0; m_dst_ok = 0; m_accept = 0; m_term = 0;
        m_ok = 0; m_drop = 0; m_ovf = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic v, input logic [63:0] d, input logic [7:0] k,
                              input logic l, input logic u, input logic f);
        logic paid;
        logic term_was;
        paid     = 1'b0;
        term_was = m_term;
        if (v) begin
            if (m_idx == 0) begin
                m_dst_ok = (wire_dst(d) == LOCAL_MAC) || (wire_dst(d) == BCAST);
                if (l) m_drop++;
            end else if (m_idx == 1) begin
                if (l) m_drop++;
                else if (m_dst_ok && wire_type(d) == ETHERTYPE && !m_term) m_accept = 1'b1;
                else begin
                    m_accept = 1'b0;
                    m_drop++;
                end
            end else if (m_accept) begin
                if (f) begin
                    m_ovf++; m_drop++; m_term = 1'b1; m_accept = 1'b0;
                end else begin
                    push_exp({~u & l, l, k, d});
                    paid = 1'b1;
                    if (l) begin
                        if (u) m_ok++;
                        else   m_drop++;
                    end
                end
            end
            if (l) begin
                m_idx    = 0;
                m_accept = 1'b0;
            end else begin
                m_idx++;
            end
        end
        if (term_was && !f && !paid) begin
            push_exp({1'b1, 1'b1, 8'h00, 64'h0});
            m_term = 1'b0;
        end
    endtask

    task automatic drive_cycle(input logic v, input logic [63:0] d, input logic [7:0] k,
                               input logic l, input logic u, input logic f);
        @(posedge clk156);
        #1;
        bus_if.s_axis_tvalid = v;
        bus_if.s_axis_tdata  = d;
        bus_if.s_axis_tkeep  = k;
        bus_if.s_axis_tlast  = l;
        bus_if.s_axis_tuser  = u;
        bus_if.full          = f;
        model_step(v, d, k, l, u, f);
    endtask

    task automatic idle(input int n, input logic f);
        for (int i = 0; i < n; i++)
            drive_cycle(1'b0, {$urandom, $urandom}, 8'h00, 1'b0, 1'b0, f);
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input int nbeats,
                              input logic user, input logic [7:0] last_keep,
                              input int gap_pct, input int full_pct);
        logic [47:0] src;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l, f;
        int          g;
        src = {$urandom, $urandom};
        for (int i = 0; i < nbeats; i++) begin
            g = ($urandom_range(99) < gap_pct) ? $urandom_range(1, 3) : 0;
            for (int j = 0; j < g; j++)
                drive_cycle(1'b0, {$urandom, $urandom}, 8'hA5, 1'b0, 1'b0,
                            ($urandom_range(99) < full_pct));
            l = (i == nbeats - 1);
            if (i == 0)      d = mk_w0(dst, src);
            else if (i == 1) d = mk_w1(src, et, 16'($urandom));
            else             d = {$urandom, $urandom};
            k = l ? last_keep : 8'hFF;
            f = ($urandom_range(99) < full_pct);
            drive_cycle(1'b1, d, k, l, l ? user : 1'b0, f);
        end
    endtask

    task automatic check(input string name, input logic [73:0] act, input logic [73:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_state(input string tag);
        @(negedge clk156);
        #2;
        check({tag, "_frames_ok"},    74'(frames_ok),    74'(m_ok));
        check({tag, "_frames_drop"},  74'(frames_drop),  74'(m_drop));
        check({tag, "_overflow_cnt"}, 74'(overflow_cnt), 74'(m_ovf));
        check({tag, "_pending_writes"}, 74'(exp_q.size()), 74'd0);
    endtask

    // Monitor: every FIFO write must match the oldest prediction and its cycle.
    always @(negedge clk156) begin
        if (bus_if.wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual din=%h required no write", bus_if.din);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus_if.din !== mon_e.din || cyc != mon_e.at) begin
                    errors++;
                    $display("FAIL fifo_write actual din=%h cyc=%0d required din=%h cyc=%0d",
                             bus_if.din, cyc, mon_e.din, mon_e.at);
                end else begin
                    $display("write din=%h cyc=%0d", bus_if.din, cyc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] src;
        sys_rst = 1'b1;
        bus_if.s_axis_tvalid = 1'b0;
        bus_if.s_axis_tdata  = '0;
        bus_if.s_axis_tkeep  = '0;
        bus_if.s_axis_tlast  = 1'b0;
        bus_if.s_axis_tuser  = 1'b0;
        bus_if.full          = 1'b0;
        model_reset();
        #2;
        check("reset_wr_en", 74'(bus_if.wr_en), 74'd0);
        check("reset_din", bus_if.din, 74'd0);
        check("reset_frames_ok", 74'(frames_ok), 74'd0);
        check("reset_frames_drop", 74'(frames_drop), 74'd0);
        check("reset_overflow_cnt", 74'(overflow_cnt), 74'd0);
        repeat (3) @(posedge clk156);
        @(negedge clk156) sys_rst = 1'b0;
        repeat (4) @(posedge clk156);

        // Good frame: 3 payload words, short last word.
        send_frame(LOCAL_MAC, ETHERTYPE, 5, 1'b1, 8'h0F, 0, 0);
        idle(3, 1'b0);
        check_state("good");
        check("good_frames_ok_is_1", 74'(frames_ok), 74'd1);

        // Wrong EtherType, then a good broadcast frame.
        send_frame(LOCAL_MAC, 16'h0800, 6, 1'b1, 8'hFF, 0, 0);
        send_frame(BCAST, ETHERTYPE, 4, 1'b1, 8'h03, 0, 0);
        idle(3, 1'b0);
        check_state("wrong_type");

        // Bad CRC: last payload word carries err.
        send_frame(LOCAL_MAC, ETHERTYPE, 4, 1'b0, 8'hFF, 0, 0);
        idle(3, 1'b0);
        check_state("bad_crc");

        // Overflow on the 2nd of 4 payload words, full released after tlast.
        src = {$urandom, $urandom};
        drive_cycle(1'b1, mk_w0(LOCAL_MAC, src), 8'hFF, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, mk_w1(src, ETHERTYPE, 16'h0007), 8'hFF, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, {$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, {$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, {$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, {$urandom, $urandom}, 8'h0F, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);
        idle(4, 1'b0);
        check_state("overflow");

        // Runts: one-beat and two-beat frames.
        send_frame(LOCAL_MAC, ETHERTYPE, 1, 1'b1, 8'hFF, 0, 0);
        send_frame(LOCAL_MAC, ETHERTYPE, 2, 1'b1, 8'hFF, 0, 0);
        idle(2, 1'b0);
        check_state("runt");

        // Header seen while a terminator is still pending: whole frame dropped.
        src = {$urandom, $urandom};
        drive_cycle(1'b1, mk_w0(LOCAL_MAC, src), 8'hFF, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, mk_w1(src, ETHERTYPE, 16'h0009), 8'hFF, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, {$urandom, $urandom}, 8'hFF, 1'b1, 1'b1, 1'b1);
        send_frame(LOCAL_MAC, ETHERTYPE, 4, 1'b1, 8'hFF, 0, 100);
        idle(3, 1'b0);
        check_state("term_pend");

        // Randomized traffic with gaps and FIFO back-pressure.
        for (int n = 0; n < 40; n++) begin
            logic [47:0] dst;
            int          sel;
            sel = $urandom_range(9);
            dst = (sel < 6) ? LOCAL_MAC : (sel < 8) ? BCAST : {$urandom, $urandom};
            send_frame(dst, ($urandom_range(9) < 8) ? ETHERTYPE : 16'h0800,
                       $urandom_range(1, 8), ($urandom_range(99) < 85),
                       8'($urandom_range(1, 255)), 20, 8);
        end
        idle(5, 1'b0);
        check_state("random");

        // Asynchronous reset in the middle of a payload.
        src = {$urandom, $urandom};
        drive_cycle(1'b1, mk_w0(LOCAL_MAC, src), 8'hFF, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, mk_w1(src, ETHERTYPE, 16'h0011), 8'hFF, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, {$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 1'b0);
        @(posedge clk156);
        #3;
        sys_rst = 1'b1;
        bus_if.s_axis_tvalid = 1'b0;
        model_reset();
        #1;
        check("midrst_wr_en", 74'(bus_if.wr_en), 74'd0);
        check("midrst_din", bus_if.din, 74'd0);
        check("midrst_frames_ok", 74'(frames_ok), 74'd0);
        check("midrst_frames_drop", 74'(frames_drop), 74'd0);
        check("midrst_overflow_cnt", 74'(overflow_cnt), 74'd0);
        repeat (2) @(posedge clk156);
        @(negedge clk156) sys_rst = 1'b0;
        repeat (4) @(posedge clk156);
        send_frame(LOCAL_MAC, ETHERTYPE, 4, 1'b1, 8'h3F, 0, 0);
        idle(3, 1'b0);
        check_state("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
